// File: rtl/counter_sched_if.sv
// Signal bundle between counter_sched, its requesters and the shared counter_100.
// slave = scheduler side, master = requester/counter side.
interface counter_sched_if #(
    parameter int NREQ  = 4,
    parameter int NUM_W = 4,
    parameter int CNT_W = 7
) ();
    logic [NREQ-1:0]       i_req;
    logic [NREQ*NUM_W-1:0] i_num;
    logic [NREQ*CNT_W-1:0] i_limit;
    logic [CNT_W-1:0]      i_cnt;
    logic [NREQ-1:0]       o_gnt;
    logic [NREQ-1:0]       o_done;
    logic [NREQ-1:0]       o_err;
    logic                  o_busy;
    logic                  o_cnt_clr;
    logic                  o_run;
    logic [NUM_W-1:0]      o_num;

    modport slave (
        input  i_req, i_num, i_limit, i_cnt,
        output o_gnt, o_done, o_err, o_busy, o_cnt_clr, o_run, o_num
    );

    modport master (
        output i_req, i_num, i_limit, i_cnt,
        input  o_gnt, o_done, o_err, o_busy, o_cnt_clr, o_run, o_num
    );
endinterface

// File: rtl/counter_sched.sv
// Round-robin scheduler sharing one counter_100 between NREQ requesters.
// Optional run-cycle watchdog: define COUNTER_SCHED_TIMEOUT_EN.
module counter_sched #(
    parameter int NREQ   = 4,
    parameter int NUM_W  = 4,
    parameter int CNT_W  = 7,
    parameter int TO_CYC = 255
) (
    input  logic           clk,
    input  logic           reset,
    counter_sched_if.slave bus
);
    localparam int PTR_W = $clog2(NREQ);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] CLEAR = 2'd1;
    localparam logic [1:0] RUN   = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);

    logic [1:0]       state_q, state_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [PTR_W-1:0] win_q, win_d;
    logic [NUM_W-1:0] num_q, num_d;
    logic [CNT_W-1:0] limit_q, limit_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [NREQ-1:0]  done_q, done_d;
    logic [NREQ-1:0]  err_q, err_d;
    logic             busy_q, busy_d;
    logic             clr_q, clr_d;
    logic             run_q, run_d;

    logic             pick_found;
    logic [PTR_W-1:0] pick_idx;
    logic [PTR_W-1:0] cand;
    int               cand_int;
    logic [NUM_W-1:0] num_sel;
    logic [CNT_W-1:0] limit_sel;
    logic             timeout;

    // Scan from the highest offset down so the nearest set bit after ptr wins last.
    always_comb begin
        // NOTE: every variable gets a default first so no path can leave it unassigned (no latch).
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        cand_int   = 0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            cand_int = int'(ptr_q) + i;
            if (cand_int >= NREQ) cand_int = cand_int - NREQ;
            cand = PTR_W'(cand_int);
            if (bus.i_req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        num_sel   = '0;
        limit_sel = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (pick_idx == PTR_W'(k)) begin
                num_sel   = bus.i_num[k*NUM_W +: NUM_W];
                limit_sel = bus.i_limit[k*CNT_W +: CNT_W];
            end
        end
    end

`ifdef COUNTER_SCHED_TIMEOUT_EN
    localparam int RC_W = ($clog2(TO_CYC + 1) > 8) ? $clog2(TO_CYC + 1) : 8;

    logic [RC_W-1:0] rc_q, rc_d;

    always_comb begin
        rc_d = rc_q;
        if (state_q == CLEAR)    rc_d = '0;
        else if (state_q == RUN) rc_d = rc_q + RC_W'(1);
    end

    // rc_q counts RUN cycles already completed, so this fires on the TO_CYC-th RUN cycle.
    assign timeout = (state_q == RUN) && (rc_q == RC_W'(TO_CYC - 1));

    always_ff @(posedge clk) begin
        if (reset) rc_q <= '0;
        else       rc_q <= rc_d;
    end
`else
    logic unused_to_cyc;
    assign unused_to_cyc = ^TO_CYC;
    assign timeout       = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        num_d   = num_q;
        limit_d = limit_q;
        gnt_d   = gnt_q;
        run_d   = run_q;
        done_d  = '0;
        err_d   = '0;
        clr_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = CLEAR;
                    win_d   = pick_idx;
                    num_d   = num_sel;
                    limit_d = limit_sel;
                    gnt_d   = ONE_HOT0 << pick_idx;
                    clr_d   = 1'b1;
                end
            end
            CLEAR: begin
                state_d = RUN;
                run_d   = 1'b1;
            end
            RUN: begin
                // Completion wins over a watchdog expiry in the same cycle.
                if (bus.i_cnt >= limit_q) begin
                    state_d = DONE;
                    run_d   = 1'b0;
                    done_d  = ONE_HOT0 << win_q;
                end else if (timeout) begin
                    state_d = DONE;
                    run_d   = 1'b0;
                    err_d   = ONE_HOT0 << win_q;
                end
            end
            DONE: begin
                state_d = IDLE;
                gnt_d   = '0;
                ptr_d   = (win_q == PTR_W'(NREQ - 1)) ? '0 : win_q + PTR_W'(1);
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            win_q   <= '0;
            num_q   <= '0;
            limit_q <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            err_q   <= '0;
            busy_q  <= 1'b0;
            clr_q   <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            num_q   <= num_d;
            limit_q <= limit_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            clr_q   <= clr_d;
            run_q   <= run_d;
        end
    end

    assign bus.o_gnt     = gnt_q;
    assign bus.o_done    = done_q;
    assign bus.o_err     = err_q;
    assign bus.o_busy    = busy_q;
    assign bus.o_cnt_clr = clr_q;
    assign bus.o_run     = run_q;
    assign bus.o_num     = num_q;
endmodule
